// File: rtl/ntt_index_seq_pkg.sv
// Shared definitions for the NTT/INTT loop-index sequencer.
//   - FSM state encoding
//   - run-mode codes (run and done flavours for each transform)
//   - Kyber per-stage group/butterfly bounds (stored minus one)
//   - helpers mapping (KD_mode, inv) to the run-mode code and the first/last stage
package ntt_index_seq_pkg;

   localparam int N_HALF = 128;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_GAP,
      ST_DONE
   } state_t;

   localparam logic [3:0] RM_IDLE        = 4'b0000;
   localparam logic [3:0] RM_K_NTT       = 4'b0011;
   localparam logic [3:0] RM_D_NTT       = 4'b0101;
   localparam logic [3:0] RM_K_INTT      = 4'b0111;
   localparam logic [3:0] RM_D_INTT      = 4'b1001;
   localparam logic [3:0] RM_K_NTT_DONE  = 4'b0100;
   localparam logic [3:0] RM_D_NTT_DONE  = 4'b0110;
   localparam logic [3:0] RM_K_INTT_DONE = 4'b1000;
   localparam logic [3:0] RM_D_INTT_DONE = 4'b1010;

   // Kyber bounds indexed by p (element [3] is stage p=3).
   // p=3: 1x128, p=2: 2x32, p=1: 8x8, p=0: 32x2
   localparam logic [3:0][6:0] KY_G_M1 = {7'd0,   7'd1,  7'd7, 7'd31};
   localparam logic [3:0][6:0] KY_B_M1 = {7'd127, 7'd31, 7'd7, 7'd1};

   function automatic logic [3:0] run_code(input logic kd, input logic inv, input logic fin);
      logic [3:0] code;
      case ({inv, kd})
         2'b00:   code = fin ? RM_K_NTT_DONE  : RM_K_NTT;
         2'b01:   code = fin ? RM_D_NTT_DONE  : RM_D_NTT;
         2'b10:   code = fin ? RM_K_INTT_DONE : RM_K_INTT;
         default: code = fin ? RM_D_INTT_DONE : RM_D_INTT;
      endcase
      return code;
   endfunction

   // Forward transforms walk p downward from the top stage, inverse ones upward from 0.
   function automatic logic [2:0] first_stage(input logic kd, input logic inv);
      return inv ? 3'd0 : (kd ? 3'd7 : 3'd3);
   endfunction

   function automatic logic [2:0] last_stage(input logic kd, input logic inv);
      return inv ? (kd ? 3'd7 : 3'd3) : 3'd0;
   endfunction

endpackage

// File: rtl/ntt_index_seq_if.sv
// Handshake/index bundle of the NTT index sequencer.
//   master: issues start/KD_mode/inv/stall, consumes indices and status
//   slave : the sequencer itself
interface ntt_index_seq_if;
   logic       start;
   logic       KD_mode;
   logic       inv;
   logic       stall;
   logic [6:0] k;
   logic [2:0] p;
   logic [6:0] j;
   logic       idx_valid;
   logic       stage_last;
   logic [3:0] run_mode;
   logic       busy;
   logic       done;

   modport master (
      output start, KD_mode, inv, stall,
      input  k, p, j, idx_valid, stage_last, run_mode, busy, done
   );

   modport slave (
      input  start, KD_mode, inv, stall,
      output k, p, j, idx_valid, stage_last, run_mode, busy, done
   );
endinterface

// File: rtl/ntt_index_seq_bounds.sv
// Combinational loop-bound decode for one NTT stage.
//   kd_mode : 0 = Kyber, 1 = Dilithium
//   p       : stage index
//   g_m1    : number of groups minus one
//   b_m1    : butterflies per group minus one
// Dilithium bounds are powers of two (G = 2^(7-p), B = 2^p), so shifts suffice.
module ntt_stage_bounds
   import ntt_index_seq_pkg::*;
(
   input  logic       kd_mode,
   input  logic [2:0] p,
   output logic [6:0] g_m1,
   output logic [6:0] b_m1
);
   logic [7:0] g_pow;
   logic [7:0] b_pow;

   always_comb begin
      b_pow = 8'd1 << p;
      g_pow = 8'd1 << (3'd7 - p);
      if (kd_mode) begin
         g_m1 = 7'(g_pow - 8'd1);
         b_m1 = 7'(b_pow - 8'd1);
      end else begin
         g_m1 = KY_G_M1[p[1:0]];
         b_m1 = KY_B_M1[p[1:0]];
      end
   end
endmodule

// File: rtl/ntt_index_seq.sv
// Loop-index sequencer for the Kyber/Dilithium NTT/INTT datapath.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of ntt_index_seq_if
//              in : start, KD_mode, inv, stall
//              out: k, p, j, idx_valid, stage_last, run_mode, busy, done
// All outputs come straight from flops. The index registers hold the index
// currently presented; each unstalled RUN cycle loads the next one.
module ntt_index_seq
   import ntt_index_seq_pkg::*;
#(
   parameter int STAGE_GAP = 3
) (
   input  logic         clk,
   input  logic         rst,
   ntt_index_seq_if.slave bus
);
   localparam int GW = $clog2(STAGE_GAP + 2);
   localparam logic [GW-1:0] GAP_LAST = (STAGE_GAP > 0) ? GW'(STAGE_GAP - 1) : '0;

   state_t        state_q, state_d;
   logic [6:0]    k_q, k_d, j_q, j_d;
   logic [2:0]    p_q, p_d;
   logic          kd_q, kd_d, inv_q, inv_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          vld_q, vld_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
   logic [3:0]    mode_q, mode_d;
   logic [6:0]    g_m1, b_m1;

   // Bounds only matter while walking a stage, where p is the registered one.
   ntt_stage_bounds u_bounds (
      .kd_mode (kd_q),
      .p       (p_q),
      .g_m1    (g_m1),
      .b_m1    (b_m1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         j_q     <= '0;
         p_q     <= '0;
         kd_q    <= 1'b0;
         inv_q   <= 1'b0;
         gap_q   <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mode_q  <= RM_IDLE;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         j_q     <= j_d;
         p_q     <= p_d;
         kd_q    <= kd_d;
         inv_q   <= inv_d;
         gap_q   <= gap_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      j_d     = j_q;
      p_d     = p_q;
      kd_d    = kd_q;
      inv_d   = inv_q;
      gap_d   = gap_q;
      vld_d   = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      mode_d  = RM_IDLE;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               kd_d    = bus.KD_mode;
               inv_d   = bus.inv;
               p_d     = first_stage(bus.KD_mode, bus.inv);
               k_d     = '0;
               j_d     = '0;
               vld_d   = 1'b1;
               busy_d  = 1'b1;
               mode_d  = run_code(bus.KD_mode, bus.inv, 1'b0);
            end
         end

         ST_RUN: begin
            busy_d = 1'b1;
            mode_d = run_code(kd_q, inv_q, 1'b0);
            if (bus.stall) begin
               // Hold the presented index but withdraw valid.
               last_d = last_q;
            end else if (last_q) begin
               k_d = '0;
               j_d = '0;
               if (p_q == last_stage(kd_q, inv_q)) begin
                  state_d = ST_DONE;
                  p_d     = '0;
                  done_d  = 1'b1;
                  mode_d  = run_code(kd_q, inv_q, 1'b1);
               end else begin
                  p_d = inv_q ? p_q + 3'd1 : p_q - 3'd1;
                  if (STAGE_GAP == 0) begin
                     // No drain bubble: first index of the next stage right away.
                     // A stage's (0,0) index is never its last (G and B are never both 1).
                     vld_d = 1'b1;
                  end else begin
                     state_d = ST_GAP;
                     gap_d   = '0;
                  end
               end
            end else begin
               vld_d = 1'b1;
               if (j_q == b_m1) begin
                  j_d = '0;
                  k_d = k_q + 7'd1;
               end else begin
                  j_d = j_q + 7'd1;
               end
               last_d = (k_d == g_m1) && (j_d == b_m1);
            end
         end

         ST_GAP: begin
            busy_d = 1'b1;
            mode_d = run_code(kd_q, inv_q, 1'b0);
            if (gap_q == GAP_LAST) begin
               state_d = ST_RUN;
               vld_d   = 1'b1;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.k          = k_q;
   assign bus.p          = p_q;
   assign bus.j          = j_q;
   assign bus.idx_valid  = vld_q;
   assign bus.stage_last = last_q;
   assign bus.run_mode   = mode_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_ntt_index_seq.sv
// Directed bench for ntt_index_seq: a STAGE_GAP=3 instance (bus_a) carries most
// scenarios, a STAGE_GAP=0 instance (bus_b) covers the bubble-free case.
module tb_ntt_index_seq;
   import ntt_index_seq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ntt_index_seq_if bus_a ();
   ntt_index_seq_if bus_b ();

   ntt_index_seq #(.STAGE_GAP(3)) u_dut (.clk(clk), .rst(rst), .bus(bus_a));
   ntt_index_seq #(.STAGE_GAP(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus_b));

   typedef struct packed {
      logic [6:0] k;
      logic [2:0] p;
      logic [6:0] j;
      logic       vld;
      logic       last;
      logic [3:0] mode;
      logic       busy;
      logic       done;
   } obs_t;

   typedef struct packed {
      logic [2:0] p;
      logic [6:0] k;
      logic [6:0] j;
      logic       last;
   } ent_t;

   int total = 0;
   int bad   = 0;

   ent_t       q[$];
   logic [2:0] pseq[$];
   obs_t       r_first, r_post;
   int         r_valid, r_gap, r_done_cyc, r_mode_bad, r_nlast, r_hold_bad;
   logic [3:0] r_done_mode;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic st, input logic kd, input logic iv);
      if (sel) begin
         bus_b.start = st; bus_b.KD_mode = kd; bus_b.inv = iv;
      end else begin
         bus_a.start = st; bus_a.KD_mode = kd; bus_a.inv = iv;
      end
   endtask

   function automatic obs_t samp(input bit sel);
      obs_t o;
      if (sel) o = '{bus_b.k, bus_b.p, bus_b.j, bus_b.idx_valid, bus_b.stage_last,
                     bus_b.run_mode, bus_b.busy, bus_b.done};
      else     o = '{bus_a.k, bus_a.p, bus_a.j, bus_a.idx_valid, bus_a.stage_last,
                     bus_a.run_mode, bus_a.busy, bus_a.done};
      return o;
   endfunction

   function automatic logic [31:0] pack_pseq();
      logic [31:0] v = '0;
      foreach (pseq[i]) v = {v[27:0], 1'b0, pseq[i]};
      return v;
   endfunction

   // Pulse start, then walk the transform cycle by cycle until done (bounded).
   // Optional stall: 5 cycles once (p=2,k=1,j=10) has been presented (bus_a only).
   task automatic run_xform(input bit sel, input logic kd, input logic iv,
                            input bit do_stall, input logic [3:0] exp_run);
      obs_t o;
      ent_t e;
      int   scnt = 0;
      bit   trig = 0;
      q.delete(); pseq.delete();
      r_valid = 0; r_gap = 0; r_done_cyc = 0; r_mode_bad = 0; r_nlast = 0; r_hold_bad = 0;
      r_done_mode = '0;
      drive(sel, 1'b1, kd, iv);
      step();
      drive(sel, 1'b0, 1'b0, 1'b0);
      for (int n = 1; n <= 1200; n++) begin
         o = samp(sel);
         if (n == 1) r_first = o;
         if (o.done) begin
            r_done_cyc  = n;
            r_done_mode = o.mode;
            break;
         end
         if (o.mode !== exp_run || o.busy !== 1'b1) r_mode_bad++;
         if (scnt > 0) begin
            if (o.vld !== 1'b0 || o.p !== 3'd2 || o.k !== 7'd1 || o.j !== 7'd10) r_hold_bad++;
            scnt--;
            if (scnt == 0) bus_a.stall = 1'b0;
         end else if (o.vld) begin
            if (pseq.size() == 0 || o.p != pseq[$]) pseq.push_back(o.p);
            if (o.last) r_nlast++;
            e.p = o.p; e.k = o.k; e.j = o.j; e.last = o.last;
            q.push_back(e);
            r_valid++;
            if (do_stall && !trig && o.p == 3'd2 && o.k == 7'd1 && o.j == 7'd10) begin
               trig = 1;
               scnt = 5;
               bus_a.stall = 1'b1;
            end
         end else begin
            r_gap++;
         end
         step();
      end
      step();
      r_post = samp(sel);
   endtask

   initial begin
      obs_t o;
      int   errs;
      int   dn;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      bus_a.stall = 1'b0;
      bus_b.stall = 1'b0;

      // Reset state
      step(); step(); step();
      chk("reset_a", {7'd0, samp(1'b0)}, 32'd0);
      chk("reset_b", {7'd0, samp(1'b1)}, 32'd0);
      rst = 1'b0;
      step();

      // Kyber NTT, STAGE_GAP=3
      run_xform(1'b0, 1'b0, 1'b0, 1'b0, RM_K_NTT);
      chk("kntt_first_idx", {r_first.vld, r_first.p, r_first.k, r_first.j}, {1'b1, 3'd3, 7'd0, 7'd0});
      chk("kntt_first_mode", r_first.mode, RM_K_NTT);
      chk("kntt_valid", r_valid, 320);
      chk("kntt_gap", r_gap, 9);
      chk("kntt_done_cyc", r_done_cyc, 330);
      chk("kntt_done_mode", r_done_mode, RM_K_NTT_DONE);
      chk("kntt_mode_run", r_mode_bad, 0);
      chk("kntt_pseq", pack_pseq(), 32'h0000_3210);
      chk("kntt_nlast", r_nlast, 4);
      chk("kntt_p3_end", q[127], {3'd3, 7'd0, 7'd127, 1'b1});
      chk("kntt_p2_start", q[128], {3'd2, 7'd0, 7'd0, 1'b0});
      chk("kntt_post", {r_post.mode, r_post.busy, r_post.done, r_post.vld}, 7'd0);

      // Dilithium INTT
      run_xform(1'b0, 1'b1, 1'b1, 1'b0, RM_D_INTT);
      chk("dintt_valid", r_valid, 1024);
      chk("dintt_done_cyc", r_done_cyc, 1046);
      chk("dintt_done_mode", r_done_mode, RM_D_INTT_DONE);
      chk("dintt_mode_run", r_mode_bad, 0);
      chk("dintt_pseq", pack_pseq(), 32'h0123_4567);
      errs = 0;
      for (int i = 0; i < 128; i++) begin
         if (q[i] !== {3'd0, 7'(i), 7'd0, (i == 127)}) errs++;
         if (q[896 + i] !== {3'd7, 7'd0, 7'(i), (i == 127)}) errs++;
      end
      chk("dintt_p0_p7_walk", errs, 0);
      chk("dintt_nlast", r_nlast, 8);
      chk("dintt_post_mode", r_post.mode, RM_IDLE);

      // Kyber INTT: stage p=1 is entries 64..127
      run_xform(1'b0, 1'b0, 1'b1, 1'b0, RM_K_INTT);
      chk("kintt_pseq", pack_pseq(), 32'h0000_0123);
      chk("kintt_valid", r_valid, 320);
      chk("kintt_gap_novalid", r_gap, 9);
      chk("kintt_done_cyc", r_done_cyc, 330);
      chk("kintt_done_mode", r_done_mode, RM_K_INTT_DONE);
      errs = 0;
      for (int i = 0; i < 64; i++)
         if (q[64 + i] !== {3'd1, 7'(i / 8), 7'(i % 8), (i == 63)}) errs++;
      chk("kintt_p1_walk", errs, 0);

      // Stall 5 cycles at (p=2,k=1,j=10) during Kyber NTT
      run_xform(1'b0, 1'b0, 1'b0, 1'b1, RM_K_NTT);
      chk("stall_hold", r_hold_bad, 0);
      chk("stall_valid", r_valid, 320);
      chk("stall_done_cyc", r_done_cyc, 335);
      // (2,1,10) is entry 128 + 32 + 10 = 170; next presented index must be j=11
      chk("stall_resume", q[171], {3'd2, 7'd1, 7'd11, 1'b0});

      // Extra start mid-run is ignored, then reset aborts
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      for (int n = 1; n < 10; n++) step();
      o = samp(1'b0);
      chk("mid_j9", {o.vld, o.p, o.k, o.j}, {1'b1, 3'd3, 7'd0, 7'd9});
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      o = samp(1'b0);
      chk("mid_start_ignored", {o.vld, o.p, o.k, o.j, o.mode}, {1'b1, 3'd3, 7'd0, 7'd10, RM_K_NTT});
      for (int n = 11; n < 20; n++) step();
      rst = 1'b1;
      step();
      chk("mid_reset_zero", {7'd0, samp(1'b0)}, 32'd0);
      step();
      rst = 1'b0;
      dn = 0;
      for (int n = 0; n < 400; n++) begin
         step();
         o = samp(1'b0);
         if (o.done || o.busy || o.vld) dn++;
      end
      chk("after_reset_quiet", dn, 0);

      // Clean restart: Dilithium NTT
      run_xform(1'b0, 1'b1, 1'b0, 1'b0, RM_D_NTT);
      chk("restart_first", {r_first.vld, r_first.p, r_first.mode}, {1'b1, 3'd7, RM_D_NTT});
      chk("restart_valid", r_valid, 1024);
      chk("restart_done_cyc", r_done_cyc, 1046);
      chk("restart_done_mode", r_done_mode, RM_D_NTT_DONE);

      // STAGE_GAP=0 Dilithium NTT: no bubbles at all
      run_xform(1'b1, 1'b1, 1'b0, 1'b0, RM_D_NTT);
      chk("gap0_valid", r_valid, 1024);
      chk("gap0_bubbles", r_gap, 0);
      chk("gap0_done_cyc", r_done_cyc, 1025);
      chk("gap0_pseq", pack_pseq(), 32'h7654_3210);
      chk("gap0_boundary", {q[127], q[128]}, {3'd7, 7'd0, 7'd127, 1'b1, 3'd6, 7'd0, 7'd0, 1'b0});
      chk("gap0_post", {r_post.mode, r_post.busy}, 5'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
